// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// byte-counter width, constant words and the pc step helper.
package if_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FULL  = 2'd2
   } fetch_state_t;

   localparam int          BYTE_CNT_W       = 2;
   localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Sequential pc step; wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_icache.sv
// 16-entry direct-mapped word cache for the fetch stage.
// Index pc[5:2], tag pc[31:6]; only the valid bits are reset.
// Instantiated by if_fetch only when IF_FETCH_ICACHE_EN is defined.
module if_icache (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:2] lookup_pc,
   output logic        hit,
   output logic [31:0] hit_word,
   input  logic        fill_en,
   input  logic [31:2] fill_pc,
   input  logic [31:0] fill_word
);

   logic [15:0] valid_q;
   logic [25:0] tag_q  [16];
   logic [31:0] data_q [16];

   logic [3:0]  lookup_idx;
   logic [3:0]  fill_idx;

   assign lookup_idx = lookup_pc[5:2];
   assign fill_idx   = fill_pc[5:2];

   // Lookup is purely combinational so a hit completes in the same cycle.
   assign hit      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_pc[31:6]);
   assign hit_word = data_q[lookup_idx];

   // Valid bits: cleared on reset, set by every fill.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= 16'h0000;
      end else if (fill_en) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag/data storage carries no reset; validity is tracked separately.
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_pc[31:6];
         data_q[fill_idx] <= fill_word;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit words from four little-endian
// byte reads, holds one word for decode and prefetches one more.
// Optional macro IF_FETCH_ICACHE_EN adds a 16-entry direct-mapped word cache.
// Handshake: decode consumes the held word in any cycle where
// if_valid=1 and stall_in=0; the memory returns a byte for mem_addr in any
// cycle where mem_req=1 and mem_byte_valid=1; dropping mem_req aborts.
import if_fetch_pkg::*;

module if_fetch #(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        stall_in,
   input  logic        jump_flag,
   input  logic [31:0] jump_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_byte_valid,
   input  logic [7:0]  mem_byte,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_ins,
   output logic [1:0]  dbg_state
);

   fetch_state_t          state_q, state_n;
   logic [31:0]           pc_q, pc_n;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_n;
   logic                  mem_req_q, mem_req_n;
   logic [31:0]           mem_addr_q, mem_addr_n;
   logic [23:0]           buf_q, buf_n;
   logic [31:0]           pf_word_q, pf_word_n;
   logic [31:0]           pf_pc_q, pf_pc_n;
   logic                  if_valid_q, if_valid_n;
   logic [31:0]           if_pc_q, if_pc_n;
   logic [31:0]           if_ins_q, if_ins_n;

   logic                  consume;
   logic                  slot_free;
   logic                  mem_done;
   logic                  hit_done;
   logic [31:0]           done_word;
   logic                  cache_hit;
   logic [31:0]           cache_word;

`ifdef IF_FETCH_ICACHE_EN
   logic fill_en;

   // Only aligned words fetched from memory are written into the cache.
   assign fill_en = rdy_in && !jump_flag && mem_done && (pc_q[1:0] == 2'b00);

   if_icache u_icache (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .lookup_pc (pc_q[31:2]),
      .hit       (cache_hit),
      .hit_word  (cache_word),
      .fill_en   (fill_en),
      .fill_pc   (pc_q[31:2]),
      .fill_word (done_word)
   );
`else
   assign cache_hit  = 1'b0;
   assign cache_word = ZERO_WORD;
`endif

   // Word-completion terms shared by the next-state logic and the cache fill.
   always_comb begin
      consume   = if_valid_q && !stall_in;
      slot_free = !if_valid_q || consume;
      mem_done  = (state_q == ST_FETCH) && mem_byte_valid && (cnt_q == 2'd3);
      hit_done  = (state_q == ST_IDLE) && (pc_q[1:0] == 2'b00) && cache_hit;
      done_word = hit_done ? cache_word : {mem_byte, buf_q};
   end

   // Next-state and datapath updates; jump overrides completion and consume.
   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      cnt_n      = cnt_q;
      mem_req_n  = mem_req_q;
      mem_addr_n = mem_addr_q;
      buf_n      = buf_q;
      pf_word_n  = pf_word_q;
      pf_pc_n    = pf_pc_q;
      if_valid_n = if_valid_q;
      if_pc_n    = if_pc_q;
      if_ins_n   = if_ins_q;

      if (jump_flag) begin
         pc_n       = jump_target;
         mem_req_n  = 1'b0;
         cnt_n      = '0;
         if_valid_n = 1'b0;
         state_n    = ST_IDLE;
      end else begin
         if (consume) begin
            if_valid_n = 1'b0;
         end
         if (mem_done || hit_done) begin
            mem_req_n = 1'b0;
            pc_n      = next_pc(pc_q);
            if (slot_free) begin
               if_valid_n = 1'b1;
               if_pc_n    = pc_q;
               if_ins_n   = done_word;
               state_n    = ST_IDLE;
            end else begin
               pf_word_n = done_word;
               pf_pc_n   = pc_q;
               state_n   = ST_FULL;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (!hit_done) begin
                  mem_req_n  = 1'b1;
                  mem_addr_n = pc_q;
                  cnt_n      = '0;
                  state_n    = ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (mem_byte_valid) begin
                  mem_addr_n = mem_addr_q + 32'd1;
                  cnt_n      = cnt_q + 2'd1;
                  case (cnt_q)
                     2'd0:    buf_n[7:0]   = mem_byte;
                     2'd1:    buf_n[15:8]  = mem_byte;
                     2'd2:    buf_n[23:16] = mem_byte;
                     default: buf_n        = buf_q;
                  endcase
               end
            end
            ST_FULL: begin
               mem_req_n = 1'b0;
               if (consume) begin
                  if_valid_n = 1'b1;
                  if_pc_n    = pf_pc_q;
                  if_ins_n   = pf_word_q;
                  state_n    = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // State register: reset first, then freeze whenever rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= ZERO_WORD;
         buf_q      <= 24'h0;
         pf_word_q  <= ZERO_WORD;
         pf_pc_q    <= ZERO_WORD;
         if_valid_q <= 1'b0;
         if_pc_q    <= ZERO_WORD;
         if_ins_q   <= ZERO_WORD;
      end else if (rdy_in) begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         cnt_q      <= cnt_n;
         mem_req_q  <= mem_req_n;
         mem_addr_q <= mem_addr_n;
         buf_q      <= buf_n;
         pf_word_q  <= pf_word_n;
         pf_pc_q    <= pf_pc_n;
         if_valid_q <= if_valid_n;
         if_pc_q    <= if_pc_n;
         if_ins_q   <= if_ins_n;
      end
   end

   // A redirect drops the request in the same cycle so the controller aborts.
   assign mem_req   = mem_req_q && !(rdy_in && jump_flag);
   assign mem_addr  = mem_addr_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_ins    = if_ins_q;
   assign dbg_state = state_q;

endmodule
